// File: rtl/data_1to2_dispatcher.sv
// Purpose: steers each whole received frame to port A or port B by its type field, or drops it.
// Latency: 1 cycle, input beat to output beat; all outputs come straight from flops.
// Backpressure: none; there is no ready input, so every accepted beat is forwarded or discarded.
module data_1to2_dispatcher #(
  parameter logic [15:0] P_TYPE_A  = 16'h0806,
  parameter logic [15:0] P_TYPE_B  = 16'h0800,
  parameter logic [15:0] P_MAX_LEN = 16'd1500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  input  logic [15:0] i_len,
  input  logic [15:0] i_type,
  output logic [7:0]  o_data_a,
  output logic        o_valid_a,
  output logic        o_last_a,
  output logic [15:0] o_len_a,
  output logic [7:0]  o_data_b,
  output logic        o_valid_b,
  output logic        o_last_b,
  output logic [15:0] o_len_b,
  output logic        o_len_err,
  output logic [15:0] o_frm_cnt_a,
  output logic [15:0] o_frm_cnt_b,
  output logic [15:0] o_drop_cnt
);

  // SYNC waits for a frame boundary after reset so a partial frame is never forwarded.
  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_FWD_A,
    ST_FWD_B,
    ST_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  data_a_q, data_a_d;
  logic        valid_a_q, valid_a_d;
  logic        last_a_q, last_a_d;
  logic [15:0] len_a_q, len_a_d;
  logic [7:0]  data_b_q, data_b_d;
  logic        valid_b_q, valid_b_d;
  logic        last_b_q, last_b_d;
  logic [15:0] len_b_q, len_b_d;
  logic        len_err_q, len_err_d;
  logic [15:0] frm_cnt_a_q, frm_cnt_a_d;
  logic [15:0] frm_cnt_b_q, frm_cnt_b_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        route_a;
  logic        route_b;
  logic        start;
  logic        frm_end;
  logic        overrun;
  logic [15:0] cnt_inc;

  // Next-state, beat routing, counters and length checking.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    data_a_d    = data_a_q;
    valid_a_d   = 1'b0;
    last_a_d    = 1'b0;
    len_a_d     = len_a_q;
    data_b_d    = data_b_q;
    valid_b_d   = 1'b0;
    last_b_d    = 1'b0;
    len_b_d     = len_b_q;
    len_err_d   = 1'b0;
    frm_cnt_a_d = frm_cnt_a_q;
    frm_cnt_b_d = frm_cnt_b_q;
    drop_cnt_d  = drop_cnt_q;
    route_a     = 1'b0;
    route_b     = 1'b0;
    start       = 1'b0;
    frm_end     = 1'b0;
    overrun     = 1'b0;
    // The beat counter saturates so a runaway frame cannot wrap it.
    cnt_inc     = (cnt_q >= P_MAX_LEN) ? P_MAX_LEN : cnt_q + 16'd1;

    case (state_q)
      ST_SYNC: begin
        if (!i_valid || i_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (i_valid) begin
          start = 1'b1;
          len_d = i_len;
          cnt_d = 16'd1;
          if (i_type == P_TYPE_A) begin
            route_a = 1'b1;
          end else if (i_type == P_TYPE_B) begin
            route_b = 1'b1;
          end else begin
            drop_cnt_d = drop_cnt_q + 16'd1;
            state_d    = i_last ? ST_IDLE : ST_DROP;
          end
        end
      end
      ST_FWD_A: begin
        if (i_valid) begin
          route_a = 1'b1;
          cnt_d   = cnt_inc;
        end
      end
      ST_FWD_B: begin
        if (i_valid) begin
          route_b = 1'b1;
          cnt_d   = cnt_inc;
        end
      end
      ST_DROP: begin
        if (i_valid && i_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    // A routed beat either ends the frame, truncates it at the length limit, or continues it.
    if (route_a || route_b) begin
      frm_end   = i_last;
      overrun   = !i_last && (cnt_d >= P_MAX_LEN);
      len_err_d = overrun || (frm_end && (cnt_d != len_d));
      if (frm_end) begin
        state_d = ST_IDLE;
      end else if (overrun) begin
        state_d = ST_DROP;
      end else begin
        state_d = route_a ? ST_FWD_A : ST_FWD_B;
      end
    end

    if (route_a) begin
      data_a_d  = i_data;
      valid_a_d = 1'b1;
      last_a_d  = frm_end || overrun;
      if (start) begin
        len_a_d = i_len;
      end
      if (frm_end || overrun) begin
        frm_cnt_a_d = frm_cnt_a_q + 16'd1;
      end
    end

    if (route_b) begin
      data_b_d  = i_data;
      valid_b_d = 1'b1;
      last_b_d  = frm_end || overrun;
      if (start) begin
        len_b_d = i_len;
      end
      if (frm_end || overrun) begin
        frm_cnt_b_d = frm_cnt_b_q + 16'd1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= ST_SYNC;
      cnt_q       <= 16'd0;
      len_q       <= 16'd0;
      data_a_q    <= 8'd0;
      valid_a_q   <= 1'b0;
      last_a_q    <= 1'b0;
      len_a_q     <= 16'd0;
      data_b_q    <= 8'd0;
      valid_b_q   <= 1'b0;
      last_b_q    <= 1'b0;
      len_b_q     <= 16'd0;
      len_err_q   <= 1'b0;
      frm_cnt_a_q <= 16'd0;
      frm_cnt_b_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      data_a_q    <= data_a_d;
      valid_a_q   <= valid_a_d;
      last_a_q    <= last_a_d;
      len_a_q     <= len_a_d;
      data_b_q    <= data_b_d;
      valid_b_q   <= valid_b_d;
      last_b_q    <= last_b_d;
      len_b_q     <= len_b_d;
      len_err_q   <= len_err_d;
      frm_cnt_a_q <= frm_cnt_a_d;
      frm_cnt_b_q <= frm_cnt_b_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_data_a    = data_a_q;
  assign o_valid_a   = valid_a_q;
  assign o_last_a    = last_a_q;
  assign o_len_a     = len_a_q;
  assign o_data_b    = data_b_q;
  assign o_valid_b   = valid_b_q;
  assign o_last_b    = last_b_q;
  assign o_len_b     = len_b_q;
  assign o_len_err   = len_err_q;
  assign o_frm_cnt_a = frm_cnt_a_q;
  assign o_frm_cnt_b = frm_cnt_b_q;
  assign o_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_data_1to2_dispatcher.sv
// Directed bench for data_1to2_dispatcher: default instance plus a P_MAX_LEN=16 instance on the same input stream.
// Inputs change 1 time unit after the rising edge; outputs are recorded on the falling edge.
// Expected values are hand-derived constants per frame.
module tb_data_1to2_dispatcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        i_last;
  logic [15:0] i_len;
  logic [15:0] i_type;

  logic [7:0]  o_data_a, o_data_b;
  logic        o_valid_a, o_valid_b, o_last_a, o_last_b, o_len_err;
  logic [15:0] o_len_a, o_len_b, o_frm_cnt_a, o_frm_cnt_b, o_drop_cnt;

  logic [7:0]  s_data_a, s_data_b;
  logic        s_valid_a, s_valid_b, s_last_a, s_last_b, s_len_err;
  logic [15:0] s_len_a, s_len_b, s_frm_cnt_a, s_frm_cnt_b, s_drop_cnt;

  data_1to2_dispatcher dut (
    .i_clk(clk), .i_rst(rst_n), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .i_len(i_len), .i_type(i_type),
    .o_data_a(o_data_a), .o_valid_a(o_valid_a), .o_last_a(o_last_a), .o_len_a(o_len_a),
    .o_data_b(o_data_b), .o_valid_b(o_valid_b), .o_last_b(o_last_b), .o_len_b(o_len_b),
    .o_len_err(o_len_err), .o_frm_cnt_a(o_frm_cnt_a), .o_frm_cnt_b(o_frm_cnt_b),
    .o_drop_cnt(o_drop_cnt)
  );

  data_1to2_dispatcher #(.P_MAX_LEN(16'd16)) dut_s (
    .i_clk(clk), .i_rst(rst_n), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .i_len(i_len), .i_type(i_type),
    .o_data_a(s_data_a), .o_valid_a(s_valid_a), .o_last_a(s_last_a), .o_len_a(s_len_a),
    .o_data_b(s_data_b), .o_valid_b(s_valid_b), .o_last_b(s_last_b), .o_len_b(s_len_b),
    .o_len_err(s_len_err), .o_frm_cnt_a(s_frm_cnt_a), .o_frm_cnt_b(s_frm_cnt_b),
    .o_drop_cnt(s_drop_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Output recorder for both instances.
  int na, nb, nlast_a, nlast_b, nerr, nerr_at_last, first_a, first_b, lastc_a, lastc_b;
  logic [7:0]  lastd_a, lastd_b;
  logic [15:0] lastlen_a, lastlen_b;
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  int ns_a, ns_b, ns_last, ns_err, ns_err_last;
  logic [7:0] ns_lastd;

  always @(negedge clk) begin
    if (o_valid_a === 1'b1) begin
      if (na == 0) first_a = cyc;
      na++;
      qa.push_back(o_data_a);
    end
    if (o_last_a === 1'b1) begin
      nlast_a++; lastc_a = cyc; lastd_a = o_data_a; lastlen_a = o_len_a;
    end
    if (o_valid_b === 1'b1) begin
      if (nb == 0) first_b = cyc;
      nb++;
      qb.push_back(o_data_b);
    end
    if (o_last_b === 1'b1) begin
      nlast_b++; lastc_b = cyc; lastd_b = o_data_b; lastlen_b = o_len_b;
    end
    if (o_len_err === 1'b1) begin
      nerr++;
      if (o_last_a === 1'b1 || o_last_b === 1'b1) nerr_at_last++;
    end
    if (s_valid_a === 1'b1) ns_a++;
    if (s_valid_b === 1'b1) ns_b++;
    if (s_last_a === 1'b1) begin
      ns_last++; ns_lastd = s_data_a;
    end
    if (s_len_err === 1'b1) begin
      ns_err++;
      if (s_last_a === 1'b1) ns_err_last++;
    end
  end

  task automatic clr();
    na = 0; nb = 0; nlast_a = 0; nlast_b = 0; nerr = 0; nerr_at_last = 0;
    first_a = -1; first_b = -1; lastc_a = -1; lastc_b = -1;
    lastd_a = 8'h0; lastd_b = 8'h0; lastlen_a = 16'h0; lastlen_b = 16'h0;
    qa.delete(); qb.delete();
    ns_a = 0; ns_b = 0; ns_last = 0; ns_err = 0; ns_err_last = 0; ns_lastd = 8'h0;
  endtask

  task automatic beat(input logic v, input logic [7:0] d, input logic l,
                      input logic [15:0] len, input logic [15:0] typ);
    @(posedge clk);
    #1;
    i_valid = v; i_data = d; i_last = l; i_len = len; i_type = typ;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 8'h00, 1'b0, 16'h0, 16'h0);
  endtask

  // Non-first beats carry inverted len/type so any late sampling shows up.
  int fstart;
  task automatic send(input logic [15:0] typ, input logic [15:0] len, input int n,
                      input logic [7:0] base, input int gap_at, input int gap_n);
    for (int i = 0; i < n; i++) begin
      beat(1'b1, 8'(base + i), (i == n - 1), (i == 0) ? len : ~len, (i == 0) ? typ : ~typ);
      if (i == 0) fstart = cyc;
      if (i + 1 == gap_at) idle(gap_n);
    end
  endtask

  int fs_a, fs_b;
  logic [15:0] base_fa_s, base_drop_s;

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_data = 8'h0; i_last = 1'b0; i_len = 16'h0; i_type = 16'h0;
    clr();

    // Reset held 3 cycles while a type-A frame is streaming, released mid-frame.
    for (int i = 0; i < 3; i++) beat(1'b1, 8'(i), 1'b0, 16'd8, 16'h0806);
    chk("rst_valid_a", o_valid_a, 0);
    chk("rst_valid_b", o_valid_b, 0);
    chk("rst_len_a", o_len_a, 0);
    chk("rst_frm_a", o_frm_cnt_a, 0);
    chk("rst_drop", o_drop_cnt, 0);
    chk("rst_len_err", o_len_err, 0);
    clr();
    rst_n = 1'b1;
    for (int i = 3; i < 8; i++) beat(1'b1, 8'(i), (i == 7), 16'd8, 16'h0806);
    idle(2);
    chk("sync_na", na, 0);
    chk("sync_nb", nb, 0);
    chk("sync_frm_a", o_frm_cnt_a, 0);
    chk("sync_drop", o_drop_cnt, 0);

    // Type A, len 28, 28 beats 0x00..0x1B.
    clr();
    send(16'h0806, 16'd28, 28, 8'h00, 0, 0);
    idle(2);
    chk("a28_na", na, 28);
    for (int i = 0; i < 28 && i < qa.size(); i++) chk("a28_byte", qa[i], i);
    chk("a28_latency", first_a - fstart, 1);
    chk("a28_last_cyc", lastc_a - fstart, 28);
    chk("a28_nlast", nlast_a, 1);
    chk("a28_last_data", lastd_a, 8'h1B);
    chk("a28_len", lastlen_a, 28);
    chk("a28_frm_a", o_frm_cnt_a, 1);
    chk("a28_len_err", nerr, 0);
    chk("a28_nb", nb, 0);
    chk("a28_len_b", o_len_b, 0);

    // Type B with a 3-cycle gap after beat 5, then a 1-beat type-A frame back-to-back.
    clr();
    send(16'h0800, 16'd20, 20, 8'h40, 5, 3);
    fs_b = fstart;
    send(16'h0806, 16'd1, 1, 8'hAA, 0, 0);
    fs_a = fstart;
    idle(2);
    chk("gap_nb", nb, 20);
    for (int i = 0; i < 20 && i < qb.size(); i++) chk("gap_byte", qb[i], 8'h40 + i);
    chk("gap_span", lastc_b - fs_b, 23);
    chk("gap_nlast_b", nlast_b, 1);
    chk("gap_len_b", lastlen_b, 20);
    chk("b2b_na", na, 1);
    chk("b2b_data", (qa.size() > 0) ? qa[0] : 8'hxx, 8'hAA);
    chk("b2b_next_cyc", first_a - lastc_b, 1);
    chk("b2b_latency", first_a - fs_a, 1);
    chk("b2b_nlast_a", nlast_a, 1);
    chk("b2b_len_a", o_len_a, 1);
    chk("b2b_frm_a", o_frm_cnt_a, 2);
    chk("b2b_frm_b", o_frm_cnt_b, 1);
    chk("b2b_len_err", nerr, 0);

    // Unmatched 10-beat frame, unmatched single-beat frame, then a normal type-B frame.
    clr();
    send(16'h86DD, 16'd10, 10, 8'h10, 0, 0);
    send(16'h1234, 16'd1, 1, 8'h77, 0, 0);
    send(16'h0800, 16'd4, 4, 8'h50, 0, 0);
    idle(2);
    chk("drop_na", na, 0);
    chk("drop_nb", nb, 4);
    chk("drop_b0", (qb.size() > 0) ? qb[0] : 8'hxx, 8'h50);
    chk("drop_b3", (qb.size() > 3) ? qb[3] : 8'hxx, 8'h53);
    chk("drop_cnt", o_drop_cnt, 2);
    chk("drop_frm_b", o_frm_cnt_b, 2);
    chk("drop_len_err", nerr, 0);

    // Short frame (len 64, last on beat 60) and a single-beat frame with len 0.
    clr();
    send(16'h0800, 16'd64, 60, 8'h00, 0, 0);
    send(16'h0806, 16'd0, 1, 8'h99, 0, 0);
    idle(2);
    chk("short_nb", nb, 60);
    chk("short_last_data", lastd_b, 8'd59);
    chk("short_len_b", lastlen_b, 64);
    chk("short_err_total", nerr, 2);
    chk("short_err_at_last", nerr_at_last, 2);
    chk("short_frm_b", o_frm_cnt_b, 3);
    chk("len0_frm_a", o_frm_cnt_a, 3);
    chk("len0_len_a", lastlen_a, 0);

    // Overrun on the P_MAX_LEN=16 instance: 20-beat type-A frame, then a 3-beat frame.
    base_fa_s = s_frm_cnt_a;
    base_drop_s = s_drop_cnt;
    clr();
    send(16'h0806, 16'd20, 20, 8'h20, 0, 0);
    idle(2);
    chk("ovr_na", ns_a, 16);
    chk("ovr_nlast", ns_last, 1);
    chk("ovr_last_data", ns_lastd, 8'h2F);
    chk("ovr_err", ns_err, 1);
    chk("ovr_err_at_last", ns_err_last, 1);
    chk("ovr_frm_a", s_frm_cnt_a - base_fa_s, 1);
    chk("ovr_drop", s_drop_cnt, base_drop_s);
    chk("ovr_dflt_na", na, 20);
    chk("ovr_dflt_err", nerr, 0);
    clr();
    send(16'h0806, 16'd3, 3, 8'h60, 0, 0);
    idle(2);
    chk("ovr_next_na", ns_a, 3);
    chk("ovr_next_err", ns_err, 0);
    chk("ovr_next_frm_a", s_frm_cnt_a - base_fa_s, 2);

    // Reset in the middle of a forwarded frame.
    clr();
    beat(1'b1, 8'h01, 1'b0, 16'd5, 16'h0806);
    beat(1'b1, 8'h02, 1'b0, 16'd5, 16'h0806);
    beat(1'b1, 8'h03, 1'b0, 16'd5, 16'h0806);
    rst_n = 1'b0;
    beat(1'b0, 8'h00, 1'b0, 16'd0, 16'h0);
    chk("mid_rst_valid_a", o_valid_a, 0);
    chk("mid_rst_frm_a", o_frm_cnt_a, 0);
    chk("mid_rst_len_a", o_len_a, 0);
    chk("mid_rst_nlast", nlast_a, 0);
    rst_n = 1'b1;
    idle(2);
    send(16'h0806, 16'd2, 2, 8'hC0, 0, 0);
    idle(2);
    chk("post_rst_na", na, 4);
    chk("post_rst_nlast", nlast_a, 1);
    chk("post_rst_frm_a", o_frm_cnt_a, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
